// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with power-of-two depth, optional first-word-fall-through read,
// almost-full/almost-empty flags, an occupancy count and sticky overflow/underflow errors.
// Latency: write-to-read is one edge. Standard mode registers read data one cycle after rd_en_i.
//   FWFT mode presents the head word combinationally.
// Backpressure: writes are dropped when full and set overflow_o. Reads are dropped when empty
//   and set underflow_o. Dropped operations never touch storage or pointers.
// Ports:
//   clk_i, areset_i          clock; asynchronous active-high reset
//   wr_data_i, wr_en_i       write side
//   rd_en_i                  read request (FWFT: pop head word)
//   clr_err_i                clears sticky overflow_o/underflow_o (a same-cycle set wins)
//   rd_data_o, rd_valid_o    read side
//   fifo_full_o, fifo_empty_o, almost_full_o, almost_empty_o, count_o   status
//   overflow_o, underflow_o  sticky error flags
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk_i,
  input  logic                  areset_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic                  clr_err_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  fifo_full_o,
  output logic                  fifo_empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_AF = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] LP_AE = (ADDR_WIDTH+1)'(AE_THRESH);

  if (ADDR_WIDTH < 1) begin : g_bad_aw
    $error("sync_fifo_flex: ADDR_WIDTH must be >= 1");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH - 1) begin : g_bad_af
    $error("sync_fifo_flex: AF_THRESH out of range 1..DEPTH-1");
  end
  if (AE_THRESH < 1 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flex: AE_THRESH out of range 1..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic [ADDR_WIDTH:0]   w_count;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // The extra pointer MSB tells full from empty when the address bits match.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                    (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_wr_acc = wr_en_i & ~w_full;
  assign w_rd_acc = rd_en_i & ~w_empty;

  assign fifo_full_o    = w_full;
  assign fifo_empty_o   = w_empty;
  assign count_o        = w_count;
  assign almost_full_o  = (w_count >= LP_AF);
  assign almost_empty_o = (w_count <= LP_AE);
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // A new error in the same cycle as clr_err_i must survive the clear.
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (wr_en_i & w_full)  | (r_overflow  & ~clr_err_i);
      r_underflow <= (rd_en_i & w_empty) | (r_underflow & ~clr_err_i);
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_data_o  = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    assign rd_valid_o = ~w_empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    always_ff @(posedge clk_i or posedge areset_i) begin
      if (areset_i) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
      end
    end

    assign rd_data_o  = r_rd_data;
    assign rd_valid_o = r_rd_valid;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
module tb_sync_fifo_flex;

  logic        clk_i = 1'b0;
  logic        areset_i;

  // Instance 0: standard registered read
  logic [31:0] wr_data0;
  logic        wr_en0, rd_en0, clr_err0;
  logic [31:0] rd_data0;
  logic        rd_valid0, full0, empty0, af0, ae0, ovf0, udf0;
  logic [4:0]  count0;

  // Instance 1: first-word-fall-through
  logic [31:0] wr_data1;
  logic        wr_en1, rd_en1, clr_err1;
  logic [31:0] rd_data1;
  logic        rd_valid1, full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0]  count1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] exp_d;

  always #5 clk_i = ~clk_i;

  sync_fifo_flex #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) u_std (
    .clk_i(clk_i), .areset_i(areset_i), .wr_data_i(wr_data0), .wr_en_i(wr_en0),
    .rd_en_i(rd_en0), .clr_err_i(clr_err0), .rd_data_o(rd_data0), .rd_valid_o(rd_valid0),
    .fifo_full_o(full0), .fifo_empty_o(empty0), .almost_full_o(af0), .almost_empty_o(ae0),
    .count_o(count0), .overflow_o(ovf0), .underflow_o(udf0)
  );

  sync_fifo_flex #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)) u_fwft (
    .clk_i(clk_i), .areset_i(areset_i), .wr_data_i(wr_data1), .wr_en_i(wr_en1),
    .rd_en_i(rd_en1), .clr_err_i(clr_err1), .rd_data_o(rd_data1), .rd_valid_o(rd_valid1),
    .fifo_full_o(full1), .fifo_empty_o(empty1), .almost_full_o(af1), .almost_empty_o(ae1),
    .count_o(count1), .overflow_o(ovf1), .underflow_o(udf1)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    areset_i = 1'b1;
    wr_data0 = '0; wr_en0 = 0; rd_en0 = 0; clr_err0 = 0;
    wr_data1 = '0; wr_en1 = 0; rd_en1 = 0; clr_err1 = 0;
    #17;
    n_checks++;
    if ({count0, empty0, ae0, full0, af0, ovf0, udf0, rd_valid0} !== {5'd0, 1'b1, 1'b1, 5'b00000}) begin
      n_fail++;
      $display("FAIL reset_flags0: got count=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b v=%b, want count=0 e=1 ae=1 others 0",
               count0, empty0, ae0, full0, af0, ovf0, udf0, rd_valid0);
    end
    n_checks++;
    if (rd_data0 !== 32'd0) begin
      n_fail++; $display("FAIL reset_rd_data0: got %h want 0", rd_data0);
    end
    n_checks++;
    if ({count1, empty1, ae1, rd_valid1, ovf1, udf1} !== {5'd0, 1'b1, 1'b1, 3'b000}) begin
      n_fail++; $display("FAIL reset_flags1: got count=%0d e=%b ae=%b v=%b, want 0 1 1 0", count1, empty1, ae1, rd_valid1);
    end
    areset_i = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      wr_en0 = 1; wr_data0 = i; q0.push_back(i);
      tick();
      n_checks++;
      if ({count0, af0, full0, empty0} !== {5'(i + 1), 1'(i + 1 >= 14), 1'(i == 15), 1'b0}) begin
        n_fail++;
        $display("FAIL fill_%0d: got count=%0d af=%b full=%b empty=%b want count=%0d af=%b full=%b empty=0",
                 i, count0, af0, full0, empty0, i + 1, (i + 1 >= 14), (i == 15));
      end
    end
    wr_en0 = 0;
    for (int i = 0; i < 16; i++) begin
      rd_en0 = 1;
      tick();
      exp_d = q0.pop_front();
      n_checks++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== exp_d) begin
        n_fail++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, rd_valid0, rd_data0, exp_d);
      end
    end
    rd_en0 = 0;
    n_checks++;
    if (empty0 !== 1'b1 || count0 !== 5'd0) begin
      n_fail++; $display("FAIL drain_empty: got empty=%b count=%0d want 1 0", empty0, count0);
    end
    tick();
    n_checks++;
    if (rd_valid0 !== 1'b0) begin
      n_fail++; $display("FAIL drain_valid_drop: got v=%b want 0", rd_valid0);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) begin
      wr_en0 = 1; wr_data0 = 32'h100 + i; q0.push_back(32'h100 + i);
      tick();
    end
    wr_data0 = 32'hBAD; wr_en0 = 1; rd_en0 = 1;   // write dropped: not queued
    tick();
    exp_d = q0.pop_front();
    n_checks++;
    if (count0 !== 5'd15 || ovf0 !== 1'b1 || full0 !== 1'b0) begin
      n_fail++; $display("FAIL ovf_state: got count=%0d ovf=%b full=%b want 15 1 0", count0, ovf0, full0);
    end
    n_checks++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== exp_d) begin
      n_fail++; $display("FAIL ovf_read: got v=%b d=%h want v=1 d=%h", rd_valid0, rd_data0, exp_d);
    end
    wr_en0 = 0; rd_en0 = 0; clr_err0 = 1;
    tick();
    clr_err0 = 0;
    n_checks++;
    if (ovf0 !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got ovf=%b want 0", ovf0);
    end
    for (int i = 0; i < 15; i++) begin
      rd_en0 = 1;
      tick();
      exp_d = q0.pop_front();
      n_checks++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== exp_d) begin
        n_fail++; $display("FAIL ovf_drain_%0d: got v=%b d=%h want v=1 d=%h", i, rd_valid0, rd_data0, exp_d);
      end
    end
    rd_en0 = 0;
    n_checks++;
    if (empty0 !== 1'b1) begin
      n_fail++; $display("FAIL ovf_empty: got empty=%b want 1", empty0);
    end
    tick();
  endtask

  task automatic test_underflow();
    wr_en0 = 1; rd_en0 = 1; wr_data0 = 32'hA5; q0.push_back(32'hA5);
    tick();
    n_checks++;
    if (count0 !== 5'd1 || udf0 !== 1'b1 || rd_valid0 !== 1'b0) begin
      n_fail++; $display("FAIL udf_state: got count=%0d udf=%b v=%b want 1 1 0", count0, udf0, rd_valid0);
    end
    wr_en0 = 0; rd_en0 = 1; clr_err0 = 1;
    tick();
    rd_en0 = 0; clr_err0 = 0;
    exp_d = q0.pop_front();
    n_checks++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== exp_d || udf0 !== 1'b0 || count0 !== 5'd0) begin
      n_fail++; $display("FAIL udf_read: got v=%b d=%h udf=%b count=%0d want v=1 d=%h udf=0 count=0",
                         rd_valid0, rd_data0, udf0, count0, exp_d);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      wr_en0 = 1; wr_data0 = 32'h5000 + i; q0.push_back(32'h5000 + i);
      tick();
    end
    for (int i = 0; i < 100; i++) begin
      wr_en0 = 1; rd_en0 = 1; wr_data0 = $urandom; q0.push_back(wr_data0);
      tick();
      exp_d = q0.pop_front();
      n_checks++;
      if ({count0, full0, empty0, af0, ae0, ovf0, udf0} !== {5'd4, 6'b000000} ||
          rd_valid0 !== 1'b1 || rd_data0 !== exp_d) begin
        n_fail++;
        $display("FAIL b2b_%0d: got count=%0d f=%b e=%b af=%b ae=%b v=%b d=%h want count=4 flags 0 v=1 d=%h",
                 i, count0, full0, empty0, af0, ae0, rd_valid0, rd_data0, exp_d);
      end
    end
    wr_en0 = 0;
    for (int i = 0; i < 4; i++) begin
      rd_en0 = 1;
      tick();
      exp_d = q0.pop_front();
      n_checks++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== exp_d) begin
        n_fail++; $display("FAIL b2b_drain_%0d: got v=%b d=%h want v=1 d=%h", i, rd_valid0, rd_data0, exp_d);
      end
    end
    rd_en0 = 0;
    tick();
  endtask

  task automatic test_fwft();
    wr_en1 = 1; wr_data1 = 32'hDEAD; q1.push_back(32'hDEAD);
    tick();
    wr_en1 = 0;
    n_checks++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== q1[0] || count1 !== 5'd1) begin
      n_fail++; $display("FAIL fwft_head: got v=%b d=%h count=%0d want v=1 d=%h count=1", rd_valid1, rd_data1, count1, q1[0]);
    end
    rd_en1 = 1;
    tick();
    rd_en1 = 0;
    void'(q1.pop_front());
    n_checks++;
    if (empty1 !== 1'b1 || rd_valid1 !== 1'b0) begin
      n_fail++; $display("FAIL fwft_pop: got empty=%b v=%b want 1 0", empty1, rd_valid1);
    end
    for (int i = 0; i < 3; i++) begin
      wr_en1 = 1; wr_data1 = 32'hC0 + i; q1.push_back(32'hC0 + i);
      tick();
    end
    wr_en1 = 0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rd_valid1 !== 1'b1 || rd_data1 !== q1[0]) begin
        n_fail++; $display("FAIL fwft_seq_%0d: got v=%b d=%h want v=1 d=%h", i, rd_valid1, rd_data1, q1[0]);
      end
      rd_en1 = 1;
      tick();
      void'(q1.pop_front());
    end
    rd_en1 = 0;
    n_checks++;
    if (rd_valid1 !== 1'b0 || empty1 !== 1'b1) begin
      n_fail++; $display("FAIL fwft_end: got v=%b empty=%b want 0 1", rd_valid1, empty1);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 9; i++) begin
      wr_en0 = 1; wr_data0 = 32'h900 + i;
      tick();
    end
    n_checks++;
    if (count0 !== 5'd9) begin
      n_fail++; $display("FAIL midrst_pre: got count=%0d want 9", count0);
    end
    wr_data0 = 32'h999;
    #3 areset_i = 1'b1;
    #1;
    n_checks++;
    if ({count0, empty0, ae0, full0, af0, rd_valid0} !== {5'd0, 1'b1, 1'b1, 3'b000} || rd_data0 !== 32'd0) begin
      n_fail++; $display("FAIL midrst_async: got count=%0d e=%b ae=%b f=%b af=%b v=%b d=%h want 0 1 1 0 0 0 0",
                         count0, empty0, ae0, full0, af0, rd_valid0, rd_data0);
    end
    q0.delete();
    wr_en0 = 0;
    #2 areset_i = 1'b0;
    tick();
    wr_en0 = 1; wr_data0 = 32'h77; q0.push_back(32'h77);
    tick();
    wr_en0 = 0; rd_en0 = 1;
    tick();
    rd_en0 = 0;
    exp_d = q0.pop_front();
    n_checks++;
    if (rd_valid0 !== 1'b1 || rd_data0 !== exp_d || empty0 !== 1'b1) begin
      n_fail++; $display("FAIL midrst_new: got v=%b d=%h empty=%b want v=1 d=%h empty=1", rd_valid0, rd_data0, empty0, exp_d);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_fwft();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
